// File: rtl/gf180mcu_pwrsw_seq_pkg.sv
// Shared types and default sizing for the staged power-switch sequencer.
package gf180mcu_pwrsw_seq_pkg;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StRampUp = 2'd1,
    StOn     = 2'd2,
    StRampDn = 2'd3
  } pwrsw_state_t;

  localparam int unsigned DefNseg = 8;
  localparam int unsigned DefDlyW = 8;

endpackage

// File: rtl/gf180mcu_pwrsw_seq_timer.sv
// Loadable step-delay down-counter; counts to zero and stays there until reloaded.
module gf180mcu_pwrsw_seq_timer #(
  parameter int unsigned DLY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DLY_W-1:0] load_val_i,
  input  logic             hold_i,
  output logic             zero_o
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!hold_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DLY_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pwrsw_seq.sv
// Staged power-switch sequencer: ramps segment enables one at a time and manages isolation.
// Optional PWRSW_SEQ_ACKIN_EN adds SW_ACK power-good feedback gating each step.
module gf180mcu_fd_sc_mcu7t5v0_pwrsw_seq
  import gf180mcu_pwrsw_seq_pkg::*;
#(
  parameter int unsigned NSEG  = DefNseg,
  parameter int unsigned DLY_W = DefDlyW
) (
  input  logic             CLK,
  input  logic             RST,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             PWR_REQ,
  input  logic [DLY_W-1:0] STEP_DLY,
`ifdef PWRSW_SEQ_ACKIN_EN
  input  logic [NSEG-1:0]  SW_ACK,
`endif
  output logic [NSEG-1:0]  SW_EN,
  output logic             ISO,
  output logic             PWR_ACK,
  output logic             BUSY
);

  pwrsw_state_t    state_q, state_d;
  logic [NSEG-1:0] sw_en_q, sw_en_d;
  logic            iso_q, iso_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            tmr_load, tmr_hold, tmr_zero, action;

  // Supply pins are physical only; nothing in the logic depends on them.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

`ifdef PWRSW_SEQ_ACKIN_EN
  // A step is only taken once the segments have confirmed the current enable pattern.
  assign action = tmr_zero && (SW_ACK == sw_en_q);
`else
  assign action = tmr_zero;
`endif

  // Idle states never consume the timer; every ramp entry reloads it.
  assign tmr_hold = (state_q == StOff) || (state_q == StOn);

  gf180mcu_pwrsw_seq_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (STEP_DLY),
    .hold_i     (tmr_hold),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sw_en_d  = sw_en_q;
    iso_d    = iso_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    tmr_load = 1'b0;
    unique case (state_q)
      StOff: begin
        if (PWR_REQ) begin
          state_d  = StRampUp;
          sw_en_d  = {sw_en_q[NSEG-2:0], 1'b1};
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      StRampUp: begin
        // Request reversal wins over a coincident step.
        if (!PWR_REQ) begin
          state_d  = StRampDn;
          tmr_load = 1'b1;
        end else if (action) begin
          if (&sw_en_q) begin
            state_d = StOn;
            iso_d   = 1'b0;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            sw_en_d  = {sw_en_q[NSEG-2:0], 1'b1};
            tmr_load = 1'b1;
          end
        end
      end
      StOn: begin
        if (!PWR_REQ) begin
          state_d  = StRampDn;
          iso_d    = 1'b1;
          ack_d    = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      StRampDn: begin
        if (PWR_REQ) begin
          state_d  = StRampUp;
          tmr_load = 1'b1;
        end else if (action) begin
          sw_en_d  = sw_en_q >> 1;
          tmr_load = 1'b1;
          if (sw_en_q[NSEG-1:1] == '0) begin
            state_d = StOff;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StOff;
      sw_en_q <= '0;
      iso_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_en_q <= sw_en_d;
      iso_q   <= iso_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign SW_EN   = sw_en_q;
  assign ISO     = iso_q;
  assign PWR_ACK = ack_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0_pwrsw_seq.sv
// Directed bench for the power-switch sequencer (NSEG=8); ACK-feedback case under PWRSW_SEQ_ACKIN_EN.
module tb_gf180mcu_fd_sc_mcu7t5v0_pwrsw_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  wire        VDD;
  wire        VSS;
  logic       PWR_REQ = 1'b0;
  logic [7:0] STEP_DLY = 8'd3;
  logic [7:0] SW_EN;
  logic       ISO, PWR_ACK, BUSY;

  int n_cmp = 0;
  int n_err = 0;

  assign VDD = 1'b1;
  assign VSS = 1'b0;

`ifdef PWRSW_SEQ_ACKIN_EN
  logic [7:0] SW_ACK;
  logic [7:0] hist [10];
  initial for (int i = 0; i < 10; i++) hist[i] = 8'h00;
  // Segment power-good trails the enable by ten cycles.
  always @(posedge CLK) begin
    hist[0] <= SW_EN;
    for (int i = 1; i < 10; i++) hist[i] <= hist[i-1];
  end
  assign SW_ACK = hist[9];
`endif

  gf180mcu_fd_sc_mcu7t5v0_pwrsw_seq #(
    .NSEG  (8),
    .DLY_W (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .VDD      (VDD),
    .VSS      (VSS),
    .PWR_REQ  (PWR_REQ),
    .STEP_DLY (STEP_DLY),
`ifdef PWRSW_SEQ_ACKIN_EN
    .SW_ACK   (SW_ACK),
`endif
    .SW_EN    (SW_EN),
    .ISO      (ISO),
    .PWR_ACK  (PWR_ACK),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] thermo(input int n);
    logic [8:0] v;
    v = (9'h1 << n) - 9'h1;
    return v[7:0];
  endfunction

  function automatic logic is_thermo(input logic [7:0] v);
    logic [8:0] w;
    w = {1'b0, v} + 9'h1;
    return (w & {1'b0, v}) == 9'h0;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_sw_en"}, 32'(SW_EN), 32'h00);
    check_eq({tag, "_iso"}, 32'(ISO), 32'h1);
    check_eq({tag, "_ack"}, 32'(PWR_ACK), 32'h0);
    check_eq({tag, "_busy"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    int n;
    logic [7:0] prev;
    // Async reset asserted between edges must take effect immediately.
    #1 RST = 1'b1;
    #2 check_idle("rst_async");
    step();
    step();
    RST = 1'b0;
    step();
    check_idle("rst_idle");

    // Ramp up, STEP_DLY=3: one new segment every 4 edges, ACK on edge 33.
    STEP_DLY = 8'd3;
    PWR_REQ  = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      step();
      n = (e + 3) / 4;
      if (n > 8) n = 8;
      check_eq($sformatf("up_sw_en_e%0d", e), 32'(SW_EN), 32'(thermo(n)));
      check_eq($sformatf("up_ack_e%0d", e), 32'(PWR_ACK), 32'(e == 33));
      check_eq($sformatf("up_iso_e%0d", e), 32'(ISO), 32'(e != 33));
      check_eq($sformatf("up_busy_e%0d", e), 32'(BUSY), 32'(e != 33));
    end

    // Ramp down: isolation first, then one segment off every 4 edges.
    PWR_REQ = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      step();
      check_eq($sformatf("dn_sw_en_e%0d", e), 32'(SW_EN), 32'(8'hFF >> ((e - 1) / 4)));
      check_eq($sformatf("dn_iso_e%0d", e), 32'(ISO), 32'h1);
      check_eq($sformatf("dn_ack_e%0d", e), 32'(PWR_ACK), 32'h0);
      check_eq($sformatf("dn_busy_e%0d", e), 32'(BUSY), 32'(e != 33));
    end

    // Reversal mid ramp-up at SW_EN=0x07.
    PWR_REQ = 1'b1;
    repeat (9) step();
    check_eq("rev_pre_sw_en", 32'(SW_EN), 32'h07);
    PWR_REQ = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      step();
      check_eq($sformatf("rev_sw_en_e%0d", e), 32'(SW_EN), 32'(thermo(3 - (e - 1) / 4)));
      check_eq($sformatf("rev_ack_e%0d", e), 32'(PWR_ACK), 32'h0);
      check_eq($sformatf("rev_busy_e%0d", e), 32'(BUSY), 32'(e != 13));
    end

    // Async reset mid-ramp drops every segment at once.
    PWR_REQ = 1'b1;
    repeat (6) step();
    check_eq("mid_pre_sw_en", 32'(SW_EN), 32'h03);
    #3 RST = 1'b1;
    #1 check_idle("rst_mid");
    PWR_REQ = 1'b0;
    #1 RST = 1'b0;
    step();
    check_idle("rst_mid_after");

    // STEP_DLY=0: one segment per edge, ACK on edge 9.
    STEP_DLY = 8'd0;
    PWR_REQ  = 1'b1;
    prev     = SW_EN;
    for (int e = 1; e <= 9; e++) begin
      step();
      check_eq($sformatf("fast_sw_en_e%0d", e), 32'(SW_EN), 32'(thermo(e > 8 ? 8 : e)));
      check_eq($sformatf("fast_thermo_e%0d", e), 32'(is_thermo(SW_EN)), 32'h1);
      check_eq($sformatf("fast_1bit_e%0d", e), 32'($countones(SW_EN ^ prev) <= 1), 32'h1);
      check_eq($sformatf("fast_ack_e%0d", e), 32'(PWR_ACK), 32'(e == 9));
      prev = SW_EN;
    end

    // Reversal in ramp-down: SW_EN holds on the reversal edge, then climbs again.
    PWR_REQ = 1'b0;
    step();
    check_eq("rdn_sw_en_1", 32'(SW_EN), 32'hFF);
    check_eq("rdn_iso_1", 32'(ISO), 32'h1);
    step();
    check_eq("rdn_sw_en_2", 32'(SW_EN), 32'h7F);
    step();
    check_eq("rdn_sw_en_3", 32'(SW_EN), 32'h3F);
    PWR_REQ = 1'b1;
    step();
    check_eq("rdn_sw_en_hold", 32'(SW_EN), 32'h3F);
    check_eq("rdn_busy_hold", 32'(BUSY), 32'h1);
    step();
    check_eq("rup_sw_en_1", 32'(SW_EN), 32'h7F);
    step();
    check_eq("rup_sw_en_2", 32'(SW_EN), 32'hFF);
    check_eq("rup_ack_2", 32'(PWR_ACK), 32'h0);
    step();
    check_eq("rup_ack_3", 32'(PWR_ACK), 32'h1);
    check_eq("rup_iso_3", 32'(ISO), 32'h0);

`ifdef PWRSW_SEQ_ACKIN_EN
    // Each step waits for SW_ACK; ACK only once every segment reports good.
    PWR_REQ = 1'b0;
    RST     = 1'b1;
    step();
    RST      = 1'b0;
    STEP_DLY = 8'd3;
    repeat (12) step();
    PWR_REQ = 1'b1;
    prev    = SW_EN;
    n       = 0;
    for (int e = 1; e <= 400 && n == 0; e++) begin
      step();
      if ((SW_EN != prev) && !is_thermo(SW_EN))
        check_eq($sformatf("ackin_thermo_e%0d", e), 32'(SW_EN), 32'h0);
      if (e == 33) check_eq("ackin_no_early_ack", 32'(PWR_ACK), 32'h0);
      if (PWR_ACK) n = e;
      prev = SW_EN;
    end
    check_eq("ackin_ack_seen", 32'(n != 0), 32'h1);
    check_eq("ackin_sw_ack_full", 32'(SW_ACK), 32'hFF);
    check_eq("ackin_late", 32'(n > 33), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
